// File: rtl/pixel_unpack_pkg.sv
// rtl/pixel_unpack_pkg.sv - shared GPU package: unpacker state encoding and RGB555 field layout
package pixel_unpack_pkg;

   typedef enum logic [1:0] {
      S15    = 2'd0,
      S24_W0 = 2'd1,
      S24_W1 = 2'd2,
      S24_W2 = 2'd3
   } state_e;

   localparam int C5_W     = 5;
   localparam int R_LSB    = 0;
   localparam int G_LSB    = 5;
   localparam int B_LSB    = 10;
   localparam int MASK_BIT = 15;

   // Advance by one accepted word; 15-bit mode never leaves S15.
   function automatic state_e next_state(input state_e s);
      unique case (s)
         S15:    return S15;
         S24_W0: return S24_W1;
         S24_W1: return S24_W2;
         S24_W2: return S24_W0;
      endcase
   endfunction

endpackage

// File: rtl/rgb555_expand.sv
// rtl/rgb555_expand.sv - 5-bit to 8-bit colour expansion by MSB replication
module rgb555_expand
   import pixel_unpack_pkg::*;
(
   input  logic [C5_W-1:0] c5_i,
   output logic [7:0]      c8_o
);

   assign c8_o = {c5_i, c5_i[4:2]};

endmodule

// File: rtl/pixel_unpack.sv
// rtl/pixel_unpack.sv - VRAM halfword to pixel unpacker (RGB555 / packed RGB24); PIXEL_UNPACK_MASK_EN adds o_mask
module pixel_unpack
   import pixel_unpack_pkg::*;
(
   input  logic        clk,
   input  logic        i_rst,
   input  logic        i_is24,
   input  logic        i_lineStart,
   input  logic        i_wordValid,
   output logic        o_wordReady,
   input  logic [15:0] i_word,
   output logic        o_pixValid,
   input  logic        i_pixReady,
   output logic [7:0]  o_r,
   output logic [7:0]  o_g,
   output logic [7:0]  o_b
`ifdef PIXEL_UNPACK_MASK_EN
   ,
   output logic        o_mask
`endif
);

   state_e      state_q, state_d, cur_state;
   logic        valid_q, valid_d;
   logic [7:0]  r_q, g_q, b_q, r_d, g_d, b_d;
   logic [15:0] w0_q, w0_d;
   logic [7:0]  w1hi_q, w1hi_d;
   logic [7:0]  r15, g15, b15;
   logic        accept;
`ifdef PIXEL_UNPACK_MASK_EN
   logic        mask_q, mask_d;
`endif

   assign o_wordReady = !valid_q || i_pixReady;
   assign accept      = i_wordValid && o_wordReady;

   rgb555_expand u_exp_r (.c5_i(i_word[R_LSB +: C5_W]), .c8_o(r15));
   rgb555_expand u_exp_g (.c5_i(i_word[G_LSB +: C5_W]), .c8_o(g15));
   rgb555_expand u_exp_b (.c5_i(i_word[B_LSB +: C5_W]), .c8_o(b15));

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= S15;
      end else begin
         state_q <= state_d;
      end
   end

   // A line start takes effect in its own cycle so a same-cycle word belongs to the new line.
   always_comb begin
      cur_state = state_q;
      if (i_lineStart) begin
         cur_state = i_is24 ? S24_W0 : S15;
      end
      state_d = accept ? next_state(cur_state) : cur_state;
   end

   always_comb begin
      valid_d = valid_q && !i_pixReady;
      r_d     = r_q;
      g_d     = g_q;
      b_d     = b_q;
      w0_d    = i_lineStart ? 16'd0 : w0_q;
      w1hi_d  = i_lineStart ? 8'd0 : w1hi_q;
`ifdef PIXEL_UNPACK_MASK_EN
      mask_d  = mask_q;
`endif
      if (accept) begin
         unique case (cur_state)
            S15: begin
               valid_d = 1'b1;
               r_d     = r15;
               g_d     = g15;
               b_d     = b15;
`ifdef PIXEL_UNPACK_MASK_EN
               mask_d  = i_word[MASK_BIT];
`endif
            end
            S24_W0: begin
               w0_d = i_word;
            end
            S24_W1: begin
               valid_d = 1'b1;
               r_d     = w0_q[7:0];
               g_d     = w0_q[15:8];
               b_d     = i_word[7:0];
               w1hi_d  = i_word[15:8];
`ifdef PIXEL_UNPACK_MASK_EN
               mask_d  = 1'b0;
`endif
            end
            S24_W2: begin
               valid_d = 1'b1;
               r_d     = w1hi_q;
               g_d     = i_word[7:0];
               b_d     = i_word[15:8];
`ifdef PIXEL_UNPACK_MASK_EN
               mask_d  = 1'b0;
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         r_q     <= 8'd0;
         g_q     <= 8'd0;
         b_q     <= 8'd0;
         w0_q    <= 16'd0;
         w1hi_q  <= 8'd0;
`ifdef PIXEL_UNPACK_MASK_EN
         mask_q  <= 1'b0;
`endif
      end else begin
         valid_q <= valid_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         w0_q    <= w0_d;
         w1hi_q  <= w1hi_d;
`ifdef PIXEL_UNPACK_MASK_EN
         mask_q  <= mask_d;
`endif
      end
   end

   assign o_pixValid = valid_q;
   assign o_r        = r_q;
   assign o_g        = g_q;
   assign o_b        = b_q;
`ifdef PIXEL_UNPACK_MASK_EN
   assign o_mask     = mask_q;
`endif

endmodule

// File: tb/tb_pixel_unpack.sv
// tb/tb_pixel_unpack.sv - self-checking bench for pixel_unpack with a byte-stream reference model
module tb_pixel_unpack;

   logic        clk = 1'b0;
   logic        i_rst, i_is24, i_lineStart, i_wordValid, o_wordReady;
   logic        o_pixValid, i_pixReady;
   logic [15:0] i_word;
   logic [7:0]  o_r, o_g, o_b;
`ifdef PIXEL_UNPACK_MASK_EN
   logic        o_mask;
`endif

   always #5 clk = ~clk;

   pixel_unpack dut (
      .clk        (clk),
      .i_rst      (i_rst),
      .i_is24     (i_is24),
      .i_lineStart(i_lineStart),
      .i_wordValid(i_wordValid),
      .o_wordReady(o_wordReady),
      .i_word     (i_word),
      .o_pixValid (o_pixValid),
      .i_pixReady (i_pixReady),
      .o_r        (o_r),
      .o_g        (o_g),
      .o_b        (o_b)
`ifdef PIXEL_UNPACK_MASK_EN
      ,
      .o_mask     (o_mask)
`endif
   );

   int          checks = 0;
   int          errors = 0;
   int          rdy_bad = 0;
   logic [24:0] exp_q[$];
   logic [24:0] obs_q[$];
   logic [7:0]  bq[$];
   logic        mode_m = 1'b0;

   // Pixel packed as {mask, r, g, b}.
   function automatic logic [24:0] pix15(input logic [15:0] w);
      int r, g, b;
      logic m;
      r = int'(w) % 32;
      g = (int'(w) / 32) % 32;
      b = (int'(w) / 1024) % 32;
`ifdef PIXEL_UNPACK_MASK_EN
      m = w[15];
`else
      m = 1'b0;
`endif
      return {m, 8'(r * 8 + r / 4), 8'(g * 8 + g / 4), 8'(b * 8 + b / 4)};
   endfunction

   function automatic logic [24:0] cur_pix();
`ifdef PIXEL_UNPACK_MASK_EN
      return {o_mask, o_r, o_g, o_b};
`else
      return {1'b0, o_r, o_g, o_b};
`endif
   endfunction

   // One clock of stimulus; records consumed pixels and updates the reference model.
   task automatic drive_cycle(input logic ls, input logic is24, input logic wv,
                              input logic [15:0] w, input logic pr);
      logic acc;
      i_lineStart = ls;
      i_is24      = is24;
      i_wordValid = wv;
      i_word      = w;
      i_pixReady  = pr;
      @(negedge clk);
      acc = wv && o_wordReady;
      if (o_wordReady !== (!o_pixValid || pr)) rdy_bad++;
      if (o_pixValid && pr) obs_q.push_back(cur_pix());
      @(posedge clk);
      #1;
      if (ls) begin
         mode_m = is24;
         bq.delete();
      end
      if (acc) begin
         if (!mode_m) begin
            exp_q.push_back(pix15(w));
         end else begin
            bq.push_back(w[7:0]);
            bq.push_back(w[15:8]);
            while (bq.size() >= 3) begin
               exp_q.push_back({1'b0, bq[0], bq[1], bq[2]});
               void'(bq.pop_front());
               void'(bq.pop_front());
               void'(bq.pop_front());
            end
         end
      end
      i_lineStart = 1'b0;
      i_wordValid = 1'b0;
   endtask

   task automatic do_reset();
      i_rst = 1'b1; i_lineStart = 1'b0; i_wordValid = 1'b0;
      i_pixReady = 1'b0; i_word = 16'd0; i_is24 = 1'b0;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      exp_q.delete(); obs_q.delete(); bq.delete();
      mode_m = 1'b0;
      rdy_bad = 0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_lineStart = 1'b0; i_wordValid = 1'b0;
      i_pixReady = 1'b0; i_word = 16'd0; i_is24 = 1'b0;
      @(posedge clk); #1;
      i_rst = 1'b0;
      drive_cycle(1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0);
      // reset wins over a simultaneous line start and handshake
      i_rst = 1'b1; i_lineStart = 1'b1; i_is24 = 1'b1; i_wordValid = 1'b1;
      i_word = 16'hFFFF; i_pixReady = 1'b1;
      @(posedge clk); #1;
      i_rst = 1'b0; i_lineStart = 1'b0; i_wordValid = 1'b0; i_pixReady = 1'b0;
      checks++;
      if (o_pixValid !== 1'b0 || {o_r, o_g, o_b} !== 24'd0 || o_wordReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: valid=%b rgb=%h ready=%b, need valid=0 rgb=000000 ready=1",
                  o_pixValid, {o_r, o_g, o_b}, o_wordReady);
      end
`ifdef PIXEL_UNPACK_MASK_EN
      checks++;
      if (o_mask !== 1'b0) begin
         errors++;
         $display("FAIL reset_mask: got %b need 0", o_mask);
      end
`endif
   endtask

   task automatic test_15bit();
      do_reset();
      drive_cycle(1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0);
      checks++;
      if (o_pixValid !== 1'b1 || {o_r, o_g, o_b} !== 24'hFFFFFF) begin
         errors++;
         $display("FAIL p15_7fff: valid=%b rgb=%h need 1 ffffff", o_pixValid, {o_r, o_g, o_b});
      end
      drive_cycle(1'b0, 1'b0, 1'b1, 16'h0010, 1'b1);
      checks++;
      if (o_pixValid !== 1'b1 || {o_r, o_g, o_b} !== 24'h840000) begin
         errors++;
         $display("FAIL p15_0010: valid=%b rgb=%h need 1 840000", o_pixValid, {o_r, o_g, o_b});
      end
      drive_cycle(1'b0, 1'b0, 1'b1, 16'h8000, 1'b1);
      checks++;
      if (cur_pix() !== pix15(16'h8000) || {o_r, o_g, o_b} !== 24'd0) begin
         errors++;
         $display("FAIL p15_8000: got %h need %h", cur_pix(), pix15(16'h8000));
      end
`ifdef PIXEL_UNPACK_MASK_EN
      checks++;
      if (o_mask !== 1'b1) begin
         errors++;
         $display("FAIL p15_mask: got %b need 1", o_mask);
      end
`endif
      drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      checks++;
      if (o_pixValid !== 1'b0) begin
         errors++;
         $display("FAIL p15_drain: valid=%b need 0", o_pixValid);
      end
   endtask

   task automatic test_24bit();
      do_reset();
      drive_cycle(1'b1, 1'b1, 1'b1, 16'h2211, 1'b1);
      checks++;
      if (o_pixValid !== 1'b0) begin
         errors++;
         $display("FAIL p24_w0_silent: valid=%b need 0", o_pixValid);
      end
      drive_cycle(1'b0, 1'b1, 1'b1, 16'h4433, 1'b1);
      checks++;
      if (o_pixValid !== 1'b1 || {o_r, o_g, o_b} !== 24'h112233) begin
         errors++;
         $display("FAIL p24_pix0: valid=%b rgb=%h need 1 112233", o_pixValid, {o_r, o_g, o_b});
      end
      drive_cycle(1'b0, 1'b1, 1'b1, 16'h6655, 1'b1);
      checks++;
      if (o_pixValid !== 1'b1 || {o_r, o_g, o_b} !== 24'h445566) begin
         errors++;
         $display("FAIL p24_pix1: valid=%b rgb=%h need 1 445566", o_pixValid, {o_r, o_g, o_b});
      end
   endtask

   task automatic test_backpressure();
      logic [24:0] held;
      do_reset();
      drive_cycle(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
      held = pix15(16'h1234);
      for (int k = 0; k < 3; k++) begin
         drive_cycle(1'b0, 1'b0, 1'b1, 16'h5678, 1'b0);
         checks++;
         if (o_pixValid !== 1'b1 || cur_pix() !== held || o_wordReady !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b pix=%h ready=%b need 1 %h 0",
                     k, o_pixValid, cur_pix(), o_wordReady, held);
         end
      end
      drive_cycle(1'b0, 1'b0, 1'b1, 16'h5678, 1'b1);
      checks++;
      if (o_pixValid !== 1'b1 || cur_pix() !== pix15(16'h5678)) begin
         errors++;
         $display("FAIL bp_release: valid=%b pix=%h need 1 %h", o_pixValid, cur_pix(), pix15(16'h5678));
      end
      drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      checks++;
      if (obs_q.size() != 2 || obs_q[0] !== held || obs_q[1] !== pix15(16'h5678)) begin
         errors++;
         $display("FAIL bp_sequence: got %0d pixels need 2 (%h then %h)",
                  obs_q.size(), held, pix15(16'h5678));
      end
   endtask

   task automatic test_line_restart();
      do_reset();
      drive_cycle(1'b1, 1'b1, 1'b1, 16'h1111, 1'b1);
      drive_cycle(1'b1, 1'b1, 1'b1, 16'hAAAA, 1'b1);
      checks++;
      if (o_pixValid !== 1'b0) begin
         errors++;
         $display("FAIL lr_stale_w0: valid=%b rgb=%h need no pixel", o_pixValid, {o_r, o_g, o_b});
      end
      drive_cycle(1'b0, 1'b1, 1'b1, 16'hBBBB, 1'b1);
      checks++;
      if (o_pixValid !== 1'b1 || {o_r, o_g, o_b} !== 24'hAAAABB) begin
         errors++;
         $display("FAIL lr_pix0: valid=%b rgb=%h need 1 aaaabb", o_pixValid, {o_r, o_g, o_b});
      end
      drive_cycle(1'b0, 1'b1, 1'b1, 16'hCCCC, 1'b1);
      checks++;
      if (o_pixValid !== 1'b1 || {o_r, o_g, o_b} !== 24'hBBCCCC) begin
         errors++;
         $display("FAIL lr_pix1: valid=%b rgb=%h need 1 bbcccc", o_pixValid, {o_r, o_g, o_b});
      end
      drive_cycle(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
      drive_cycle(1'b1, 1'b0, 1'b1, 16'h7FFF, 1'b0);
      drive_cycle(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
      checks++;
      if (o_pixValid !== 1'b1 || {o_r, o_g, o_b} !== 24'hFFFFFF) begin
         errors++;
         $display("FAIL lr_keep_pixel: valid=%b rgb=%h need 1 ffffff", o_pixValid, {o_r, o_g, o_b});
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive_cycle(1'b1, 1'b1, 1'b1, 16'h2211, 1'b0);
      drive_cycle(1'b0, 1'b1, 1'b1, 16'h4433, 1'b0);
      i_rst = 1'b1; i_wordValid = 1'b1; i_word = 16'h6655; i_pixReady = 1'b1;
      @(posedge clk); #1;
      i_rst = 1'b0; i_wordValid = 1'b0;
      checks++;
      if (o_pixValid !== 1'b0) begin
         errors++;
         $display("FAIL rm_valid: valid=%b need 0", o_pixValid);
      end
      mode_m = 1'b0; bq.delete();
      drive_cycle(1'b0, 1'b1, 1'b1, 16'h001F, 1'b1);
      checks++;
      if (o_pixValid !== 1'b1 || {o_r, o_g, o_b} !== 24'hFF0000) begin
         errors++;
         $display("FAIL rm_15mode: valid=%b rgb=%h need 1 ff0000", o_pixValid, {o_r, o_g, o_b});
      end
   endtask

   task automatic test_mode_ignore();
      do_reset();
      drive_cycle(1'b0, 1'b1, 1'b1, 16'h0421, 1'b1);
      checks++;
      if (o_pixValid !== 1'b1 || cur_pix() !== pix15(16'h0421)) begin
         errors++;
         $display("FAIL mi_15: valid=%b pix=%h need 1 %h", o_pixValid, cur_pix(), pix15(16'h0421));
      end
      drive_cycle(1'b1, 1'b1, 1'b1, 16'h2211, 1'b1);
      drive_cycle(1'b0, 1'b0, 1'b1, 16'h4433, 1'b1);
      checks++;
      if (o_pixValid !== 1'b1 || {o_r, o_g, o_b} !== 24'h112233) begin
         errors++;
         $display("FAIL mi_24: valid=%b rgb=%h need 1 112233", o_pixValid, {o_r, o_g, o_b});
      end
   endtask

   task automatic test_back_to_back();
      int vcnt;
      do_reset();
      vcnt = 0;
      for (int k = 0; k < 8; k++) begin
         drive_cycle(k == 0, 1'b0, 1'b1, 16'($urandom), 1'b1);
         if (o_pixValid) vcnt++;
      end
      checks++;
      if (vcnt != 8 || rdy_bad != 0) begin
         errors++;
         $display("FAIL b2b_15: pixels=%0d ready_errs=%0d need 8 and 0", vcnt, rdy_bad);
      end
      drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      vcnt = 0;
      for (int k = 0; k < 6; k++) begin
         drive_cycle(k == 0, 1'b1, 1'b1, 16'($urandom), 1'b1);
         if (o_pixValid) vcnt++;
      end
      drive_cycle(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
      checks++;
      if (vcnt != 4 || obs_q.size() != exp_q.size() || obs_q != exp_q) begin
         errors++;
         $display("FAIL b2b_24: pixels=%0d obs=%0d exp=%0d need 4 and matching queues",
                  vcnt, obs_q.size(), exp_q.size());
      end
   endtask

   task automatic test_stream15();
      do_reset();
      drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      for (int c = 0; c < 8000 && exp_q.size() < 1000; c++) begin
         drive_cycle(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                     16'($urandom), $urandom_range(0, 3) != 0);
      end
      for (int c = 0; c < 4; c++) drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      checks++;
      if (exp_q.size() != 1000 || obs_q.size() != exp_q.size() || rdy_bad != 0) begin
         errors++;
         $display("FAIL s15_count: obs=%0d exp=%0d (need 1000 each) ready_errs=%0d",
                  obs_q.size(), exp_q.size(), rdy_bad);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL s15_pix%0d: got %h need %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_stream24();
      logic ls;
      do_reset();
      drive_cycle(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
      for (int c = 0; c < 600; c++) begin
         ls = ($urandom_range(0, 39) == 0);
         drive_cycle(ls, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     16'($urandom), $urandom_range(0, 2) != 0);
      end
      for (int c = 0; c < 4; c++) drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      checks++;
      if (obs_q.size() != exp_q.size() || exp_q.size() == 0 || rdy_bad != 0) begin
         errors++;
         $display("FAIL s24_count: obs=%0d exp=%0d ready_errs=%0d",
                  obs_q.size(), exp_q.size(), rdy_bad);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL s24_pix%0d: got %h need %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_15bit();
      test_24bit();
      test_backpressure();
      test_line_restart();
      test_reset_mid();
      test_mode_ignore();
      test_back_to_back();
      test_stream15();
      test_stream24();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_unpack.md
PIXEL_UNPACK -- requirements
Module: pixel_unpack

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_is24  in  1  mode: 0 = 15-bit (RGB555), 1 = 24-bit packed; sampled only at line start.
- i_lineStart  in  1  one-cycle pulse; starts a new scanline and realigns packing.
- i_wordValid  in  1  VRAM word valid.
- o_wordReady  out  1  word accepted when i_wordValid && o_wordReady.
- i_word  in  16  VRAM halfword.
- o_pixValid  out  1  output pixel valid.
- i_pixReady  in  1  pixel consumed when o_pixValid && i_pixReady.
- o_r / o_g / o_b  out  8 each  expanded 8-bit colour.
- o_mask  out  1  mask bit of the 15-bit word; present only under PIXEL_UNPACK_MASK_EN.

Function
REQ-003 SHALL hold a single registered output stage; o_wordReady = !o_pixValid || i_pixReady, combinational.
REQ-004 15-bit mode SHALL convert each accepted word into one pixel: R = word[4:0], G = word[9:5], B = word[14:10], each expanded by bit replication as {c5, c5[4:2]}.
REQ-005 15-bit latency SHALL be one cycle: o_pixValid rises on the edge after acceptance.
REQ-006 24-bit mode SHALL consume words W0, W1, W2 per pixel pair: pix0 = {R=W0[7:0], G=W0[15:8], B=W1[7:0]}; pix1 = {R=W1[15:8], G=W2[7:0], B=W2[15:8]}.
REQ-007 24-bit: pix0 SHALL become valid one cycle after W1 is accepted; pix1 one cycle after W2 is accepted; accepting W0 SHALL produce no output.
REQ-008 State machine states: S15, S24_W0, S24_W1, S24_W2.
- S24_W0 -> S24_W1 -> S24_W2 -> S24_W0, each advancing on word acceptance.
- S15 self-loops.
REQ-009 Holding registers: W0 bytes and W1[15:8] SHALL be kept until consumed; they are never exposed directly.
REQ-010 i_lineStart SHALL latch i_is24 and force the state to S15 or S24_W0; partially gathered 24-bit bytes SHALL be discarded.
REQ-011 i_lineStart SHALL NOT drop a pixel already held in the output stage.
REQ-012 A word accepted in the same cycle as i_lineStart SHALL be treated as the first word of the new line, under the new mode.
REQ-013 Under backpressure (o_pixValid && !i_pixReady), o_r/o_g/o_b/o_mask SHALL be held stable and no word SHALL be accepted.
REQ-014 Simultaneous pixel consume and word accept SHALL sustain full throughput: 1 pixel/cycle in 15-bit mode, 2 pixels per 3 cycles in 24-bit mode.
REQ-015 A change of i_is24 outside i_lineStart SHALL have no effect.

Reset
REQ-016 With i_rst high at a clock edge, the following SHALL result: o_pixValid = 0, o_r = o_g = o_b = 0, o_mask = 0, state = S15, latched mode = 15-bit, holding registers = 0.
REQ-017 Reset SHALL override a simultaneous i_lineStart or handshake; in-flight bytes and pixels are lost.

Configuration
REQ-018 Macro PIXEL_UNPACK_MASK_EN:
- Defined: o_mask exists; it carries word[15] in 15-bit mode and is 0 in 24-bit mode, held like the colour outputs.
- Undefined: the port is absent and word[15] is ignored.

Structure
REQ-019 The state encoding (S15, S24_W0, S24_W1, S24_W2) and the bit-field positions of the 15-bit word SHALL live in the shared GPU package.
REQ-020 The 5-to-8-bit expansion SHALL be a combinational sub-module rgb555_expand, instantiated three times.

Verification
REQ-021 15-bit: word 0x7FFF -> R = G = B = 0xFF; word 0x0010 -> R = 0x84, G = 0, B = 0; word 0x8000 -> all 0x00 and o_mask = 1 (macro on).
REQ-022 24-bit: lineStart with is24 = 1, then words 0x2211, 0x4433, 0x6655 -> pix0 = (0x11, 0x22, 0x33), pix1 = (0x44, 0x55, 0x66), with no output after the first word.
REQ-023 Backpressure: hold i_pixReady = 0 for 3 cycles with a pixel valid -> outputs stable and o_wordReady = 0; release -> next pixel follows with no loss.
REQ-024 Line restart: 24-bit mode, lineStart after W0 only, then 0xAAAA, 0xBBBB, 0xCCCC -> pix0 = (0xAA, 0xAA, 0xBB); the stale W0 is never emitted.
REQ-025 Reset mid-triple (after W1 with a pixel pending) -> next cycle o_pixValid = 0 and mode = 15-bit; next word 0x001F -> R = 0xFF.
REQ-026 Streaming: 1000 random 15-bit words with random i_pixReady -> output matches the reference model in order, with no drops or duplicates.
